dmem_sync: RTL and testbench
============================

DMEM_SYNC -- requirements
Module: dmem_sync

Interface
- REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits.
- REQ-002 SHALL have parameter ADDR_W, default 8: address port width.
- REQ-003 SHALL have parameter DEPTH, default 32: number of words; DEPTH <= 2**ADDR_W, DEPTH even.
- REQ-004 SHALL have parameter STATE_W, default 3, and WR_STATE, default 3: CPU state width and the state value that enables writes.
- REQ-005 SHALL have port Clk, input, 1: the single clock; all state updates on rising edge.
- REQ-006 SHALL have port Clear, input, 1: asynchronous, active-high reset.
- REQ-007 SHALL have port state, input, STATE_W: CPU phase; writes are gated by it.
- REQ-008 SHALL have port Req, input, 1: access request, one per cycle.
- REQ-009 SHALL have port We, input, 1: with Req, 1 means write and 0 means read.
- REQ-010 SHALL have port Address, input, ADDR_W: word address.
- REQ-011 SHALL have port Write_Data, input, DATA_W: write data.
- REQ-012 SHALL have port Read_Data, output, DATA_W: registered read data.
- REQ-013 SHALL have port Valid, output, 1: one-cycle pulse marking Read_Data updated by an accepted read.
- REQ-014 SHALL have port Ready, output, 1: high when initialisation is done and requests are accepted.
- REQ-015 SHALL have port Err, output, 1: one-cycle pulse on an accepted request with Address >= DEPTH.

Function
- REQ-016 SHALL implement a two-state FSM: S_INIT (sweep) and S_RUN; S_INIT -> S_RUN when the init counter reaches DEPTH-1.
- REQ-017 In S_INIT, SHALL write one entry per cycle at counter i: i for i < DEPTH/2, else (2**DATA_W - (i - DEPTH/2)) mod 2**DATA_W.
- REQ-018 Ready SHALL be 0 in S_INIT and 1 in S_RUN; Ready rises the cycle after the last init write.
- REQ-019 Requests while Ready=0 SHALL be ignored: no write, no Valid, no Err.
- REQ-020 Reads (Req=1, We=0, Ready=1, Address < DEPTH) SHALL load Read_Data with mem[Address] at the next edge, with Valid=1 for that one cycle (latency 1).
- REQ-021 Writes (Req=1, We=1, Ready=1, state==WR_STATE, Address < DEPTH) SHALL update mem[Address] at the edge; Valid stays 0.
- REQ-022 A write with state != WR_STATE SHALL be dropped silently, with no Err.
- REQ-023 A request with Address >= DEPTH SHALL leave memory unchanged, pulse Err for one cycle, and for a read also load Read_Data=0 with Valid=1.
- REQ-024 Read_Data SHALL hold its last value when no read is accepted.
- REQ-025 A read issued the cycle after a write to the same address SHALL return the new data.

Reset
- REQ-026 Clear=1 SHALL immediately force: FSM=S_INIT, init counter=0, Read_Data=0, Valid=0, Err=0, Ready=0.
- REQ-027 Clear asserted mid-sweep or mid-operation SHALL restart the sweep from index 0 after release.
- REQ-028 Memory contents SHALL not be reset by Clear itself; only the sweep defines them.

Configuration
- REQ-029 Macro DMEM_INIT_SWEEP_EN: when defined, REQ-016/017 apply (DEPTH-cycle sweep after Clear).
- REQ-030 When DMEM_INIT_SWEEP_EN is undefined, the FSM SHALL enter S_RUN on the first edge after Clear release, with Ready=1 from then on and memory contents undefined.

Structure
- REQ-031 Package dmem_pkg SHALL hold the FSM state enum (S_INIT, S_RUN), the init-pattern function, and the parameter defaults.
- REQ-032 The storage array SHALL be a sub-module dmem_array: one write port and one synchronous read port, with no reset.

Verification (DATA_W=8, DEPTH=32, WR_STATE=3)
- REQ-033 Pulse Clear, then wait -> Ready rises 32 cycles after release; reads of addresses 0, 15, 16, 17, 31 return 0x00, 0x0f, 0x00, 0xff, 0xf1, each with a one-cycle Valid.
- REQ-034 Write 0xA5 to address 5 with state=3, read address 5 next cycle -> Read_Data=0xA5; the same write with state=2 leaves 0x05.
- REQ-035 Read address 40 -> Err and Valid pulse together, Read_Data=0x00; a write to address 40 pulses Err only, and memory is unchanged.
- REQ-036 Assert Clear at sweep index 10, then release -> Ready low for 32 full cycles; address 31 reads 0xf1.
- REQ-037 Issue requests with Ready=0 -> no Valid, no Err; memory matches the init pattern.
- REQ-038 Build with DMEM_INIT_SWEEP_EN undefined -> Ready=1 one cycle after Clear release; a write then read of address 7 with 0x3C returns 0x3C.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, parameter defaults and init-pattern helper for the dmem_sync data memory.
// The DMEM_INIT_SWEEP_EN build option selects whether the init pattern is swept in after Clear.
package dmem_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 8;
    localparam int DEPTH_DEF    = 32;
    localparam int STATE_W_DEF  = 3;
    localparam int WR_STATE_DEF = 3;

    typedef enum logic {
        S_INIT,
        S_RUN
    } dmem_state_e;

    // Lower half counts up from 0; upper half counts down from 0 modulo 2**DATA_W.
    // Returned as a signed int so that truncation to DATA_W yields the modular value.
    function automatic int init_pattern(input int idx, input int depth);
        return (idx < depth / 2) ? idx : -(idx - depth / 2);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Plain storage array for dmem_sync: one write port and one synchronous, enabled read port.
// Contents are never reset.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              Clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with a post-Clear init sweep, state-gated writes and range checking.
// Define DMEM_INIT_SWEEP_EN to sweep the init pattern in; otherwise the memory is ready one cycle after Clear.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int STATE_W  = STATE_W_DEF,
    parameter int WR_STATE = WR_STATE_DEF
) (
    input  logic               Clk,
    input  logic               Clear,
    input  logic [STATE_W-1:0] state,
    input  logic               Req,
    input  logic               We,
    input  logic [ADDR_W-1:0]  Address,
    input  logic [DATA_W-1:0]  Write_Data,
    output logic [DATA_W-1:0]  Read_Data,
    output logic               Valid,
    output logic               Ready,
    output logic               Err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    dmem_state_e       fsm;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic              zero_q;
    logic              accepted;
    logic              in_range;
    logic              rd_ok;
    logic              wr_ok;
    logic              arr_we;
    logic [AW-1:0]     arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    // Handshake: a request is taken on any rising edge where Req=1 and Ready=1; there is no
    // backpressure beyond Ready, and requests presented while Ready=0 are discarded, not held.
    assign accepted = Req && ready_q;
    assign in_range = {1'b0, Address} < DEPTH_L;
    assign rd_ok    = accepted && !We && in_range;
    assign wr_ok    = accepted && We && in_range && (state == STATE_W'(WR_STATE));

`ifdef DMEM_INIT_SWEEP_EN
    logic [AW-1:0] init_cnt;

    assign arr_we    = (fsm == S_INIT) || wr_ok;
    assign arr_waddr = (fsm == S_INIT) ? init_cnt : Address[AW-1:0];
    assign arr_wdata = (fsm == S_INIT) ? DATA_W'(init_pattern(int'(init_cnt), DEPTH)) : Write_Data;
`else
    assign arr_we    = wr_ok;
    assign arr_waddr = Address[AW-1:0];
    assign arr_wdata = Write_Data;
`endif

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .Clk     (Clk),
        .wr_en   (arr_we),
        .wr_addr (arr_waddr),
        .wr_data (arr_wdata),
        .rd_en   (rd_ok),
        .rd_addr (Address[AW-1:0]),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            fsm     <= S_INIT;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
`ifdef DMEM_INIT_SWEEP_EN
            init_cnt <= '0;
`endif
        end else begin
            valid_q <= accepted && !We;
            err_q   <= accepted && !in_range;
            // Out-of-range reads return zero without disturbing the array's read register.
            if (accepted && !We) begin
                zero_q <= !in_range;
            end
            case (fsm)
                S_INIT: begin
`ifdef DMEM_INIT_SWEEP_EN
                    if (init_cnt == AW'(DEPTH - 1)) begin
                        fsm     <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
`else
                    fsm     <= S_RUN;
                    ready_q <= 1'b1;
`endif
                end
                S_RUN:   ready_q <= 1'b1;
                default: fsm <= S_INIT;
            endcase
        end
    end

    assign Read_Data = zero_q ? '0 : arr_rdata;
    assign Valid     = valid_q;
    assign Ready     = ready_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed testbench for dmem_sync (DATA_W=8, DEPTH=32, WR_STATE=3), in both sweep and no-sweep builds.
module tb_dmem_sync;

`ifdef DMEM_INIT_SWEEP_EN
    localparam int INIT_CYC = 32;
`else
    localparam int INIT_CYC = 1;
`endif

    logic       Clk = 1'b0;
    logic       Clear;
    logic [2:0] state;
    logic       Req;
    logic       We;
    logic [7:0] Address;
    logic [7:0] Write_Data;
    logic [7:0] Read_Data;
    logic       Valid;
    logic       Ready;
    logic       Err;

    int checks   = 0;
    int failures = 0;

    dmem_sync #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .DEPTH    (32),
        .STATE_W  (3),
        .WR_STATE (3)
    ) dut (
        .Clk        (Clk),
        .Clear      (Clear),
        .state      (state),
        .Req        (Req),
        .We         (We),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .Valid      (Valid),
        .Ready      (Ready),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [2:0] st);
        Req = 1'b1; We = 1'b1; Address = a; Write_Data = d; state = st;
        tick();
        Req = 1'b0; We = 1'b0; state = 3'd3;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp_d,
                            input logic exp_err);
        Req = 1'b1; We = 1'b0; Address = a;
        tick();
        Req = 1'b0;
        chk({tag, "_valid"}, 32'(Valid), 32'(1'b1));
        chk({tag, "_data"}, 32'(Read_Data), 32'(exp_d));
        chk({tag, "_err"}, 32'(Err), 32'(exp_err));
    endtask

    // Counts cycles until Ready, checking that whatever is on the request pins is ignored.
    task automatic wait_init(input string tag);
        int n = 0;
        while (Ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            chk({tag, "_nr_valid"}, 32'(Valid), 32'd0);
            chk({tag, "_nr_err"}, 32'(Err), 32'd0);
        end
        Req = 1'b0; We = 1'b0;
        chk(tag, 32'(n), 32'(INIT_CYC));
    endtask

    initial begin
        Clear = 1'b1; state = 3'd3; Req = 1'b0; We = 1'b0; Address = '0; Write_Data = '0;
        tick();
        tick();
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_rdata", 32'(Read_Data), 32'd0);
        Req = 1'b1; We = 1'b0; Address = 8'd40;
        tick();
        chk("clr_req_valid", 32'(Valid), 32'd0);
        chk("clr_req_err", 32'(Err), 32'd0);

        // Release with a write pending that must be ignored until Ready.
        Clear = 1'b0;
        Req = 1'b1; We = 1'b1; Address = 8'd3; Write_Data = 8'h77; state = 3'd3;
        wait_init("init_cycles");

`ifdef DMEM_INIT_SWEEP_EN
        read_chk("pat0", 8'd0, 8'h00, 1'b0);
        read_chk("pat15", 8'd15, 8'h0f, 1'b0);
        read_chk("pat16", 8'd16, 8'h00, 1'b0);
        read_chk("pat17", 8'd17, 8'hff, 1'b0);
        read_chk("pat31", 8'd31, 8'hf1, 1'b0);
        tick();
        chk("idle_valid", 32'(Valid), 32'd0);
        chk("idle_hold", 32'(Read_Data), 32'hf1);
        read_chk("ignored_wr3", 8'd3, 8'h03, 1'b0);
`else
        do_write(8'd7, 8'h3c, 3'd3);
        chk("wr7_valid", 32'(Valid), 32'd0);
        read_chk("rd7", 8'd7, 8'h3c, 1'b0);
        tick();
        chk("idle_valid", 32'(Valid), 32'd0);
        chk("idle_hold", 32'(Read_Data), 32'h3c);
`endif

        do_write(8'd8, 8'h08, 3'd3);
        do_write(8'd5, 8'h05, 3'd3);
        do_write(8'd5, 8'ha5, 3'd2);
        chk("gated_wr_err", 32'(Err), 32'd0);
        chk("gated_wr_valid", 32'(Valid), 32'd0);
        read_chk("gated_rd5", 8'd5, 8'h05, 1'b0);
        do_write(8'd5, 8'ha5, 3'd3);
        chk("wr5_valid", 32'(Valid), 32'd0);
        read_chk("rd5_after_wr", 8'd5, 8'ha5, 1'b0);
        tick();
        chk("hold_a5", 32'(Read_Data), 32'ha5);

        read_chk("oor_rd40", 8'd40, 8'h00, 1'b1);
        tick();
        chk("oor_err_pulse", 32'(Err), 32'd0);
        chk("oor_valid_pulse", 32'(Valid), 32'd0);
        chk("oor_hold0", 32'(Read_Data), 32'd0);
        read_chk("oor_rd32", 8'd32, 8'h00, 1'b1);
        do_write(8'd40, 8'hee, 3'd3);
        chk("oor_wr_err", 32'(Err), 32'd1);
        chk("oor_wr_valid", 32'(Valid), 32'd0);
        tick();
        chk("oor_wr_err_pulse", 32'(Err), 32'd0);
        read_chk("alias8_unchanged", 8'd8, 8'h08, 1'b0);
        do_write(8'd9, 8'h99, 3'd3);
        chk("hold_over_wr", 32'(Read_Data), 32'h08);
        read_chk("rd9", 8'd9, 8'h99, 1'b0);

`ifdef DMEM_INIT_SWEEP_EN
        Clear = 1'b1;
        #1;
        chk("clr_async_ready", 32'(Ready), 32'd0);
        chk("clr_async_rdata", 32'(Read_Data), 32'd0);
        tick();
        Clear = 1'b0;
        repeat (10) tick();
        Clear = 1'b1;
        #1;
        chk("midsweep_ready", 32'(Ready), 32'd0);
        tick();
        Clear = 1'b0;
        Req = 1'b1; We = 1'b0; Address = 8'd40;
        wait_init("resweep_cycles");
        read_chk("resweep31", 8'd31, 8'hf1, 1'b0);
        read_chk("resweep5", 8'd5, 8'h05, 1'b0);
        read_chk("resweep9", 8'd9, 8'h09, 1'b0);
`else
        do_write(8'd3, 8'h22, 3'd3);
        Clear = 1'b1;
        #1;
        chk("clr_async_ready", 32'(Ready), 32'd0);
        chk("clr_async_rdata", 32'(Read_Data), 32'd0);
        tick();
        Clear = 1'b0;
        Req = 1'b1; We = 1'b1; Address = 8'd3; Write_Data = 8'h77; state = 3'd3;
        wait_init("reinit_cycles");
        read_chk("kept3", 8'd3, 8'h22, 1'b0);
        read_chk("kept9", 8'd9, 8'h99, 1'b0);
        read_chk("kept7", 8'd7, 8'h3c, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
